// File: rtl/bsg_mem_1r1w_sync_clear.sv
// bsg_mem_1r1w_sync_clear
//   1-read/1-write register-file memory with a registered read port, a per-bit
//   write mask and optional write-through for same-address read/write. A sweep
//   FSM loads init_val_p into every entry after reset (clear_on_reset_p=1) or
//   when clear_i is seen in READY.
//
// Ports
//   clk_i      clock, all state updates on posedge
//   reset_n_i  asynchronous active-low reset
//   clear_i    start a clear sweep (sampled only in READY)
//   ready_o    array accepts reads/writes
//   w_v_i      write valid
//   w_addr_i   write address
//   w_data_i   write data
//   w_mask_i   per-bit write enable (1 = write bit)
//   r_v_i      read valid
//   r_addr_i   read address
//   r_data_o   registered read data (holds when no read accepted)
//   r_v_o      r_data_o carries a fresh read result this cycle
//
// States
//   state   | meaning
//   READY   | array usable, clear_i starts a sweep
//   CLEAR   | writing init_val_p to entry cnt_r, one entry per cycle
module bsg_mem_1r1w_sync_clear #(
    parameter int width_p          = 8,
    parameter int els_p            = 4,
    parameter int write_through_p  = 0,
    parameter int clear_on_reset_p = 1,
    parameter logic [width_p-1:0] init_val_p = '0,
    // set to 0 to silence the out-of-range access report
    parameter int sim_oob_check_p  = 1,
    localparam int addr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     clear_i,
    output logic                     ready_o,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [width_p-1:0]       w_mask_i,
    input  logic                     r_v_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o,
    output logic                     r_v_o
);

    localparam logic [0:0] S_READY = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;
    localparam logic [0:0] reset_state_lp = (clear_on_reset_p != 0) ? S_CLEAR : S_READY;

    localparam logic [addr_width_lp-1:0] last_lp = addr_width_lp'(els_p - 1);
    localparam logic [addr_width_lp:0]   els_lp  = (addr_width_lp + 1)'(els_p);

    logic [width_p-1:0]       mem [els_p];

    logic [0:0]               state_r, state_n;
    logic [addr_width_lp-1:0] cnt_r, cnt_n;

    logic                     w_in_range, r_in_range;
    logic                     w_accept, r_accept;
    logic [width_p-1:0]       w_merge;
    logic [width_p-1:0]       r_data_n;

    assign ready_o = (state_r == S_READY);

    // Non-power-of-2 depths leave address codes with no backing entry.
    assign w_in_range = ({1'b0, w_addr_i} < els_lp);
    assign r_in_range = ({1'b0, r_addr_i} < els_lp);

    assign w_accept = w_v_i & ready_o & w_in_range;
    assign r_accept = r_v_i & ready_o;

    assign w_merge = (mem[w_addr_i] & ~w_mask_i) | (w_data_i & w_mask_i);

    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        if (state_r == S_READY) begin
            if (clear_i) begin
                state_n = S_CLEAR;
            end
        end else begin
            if (cnt_r == last_lp) begin
                state_n = S_READY;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt_r + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= reset_state_lp;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    always_comb begin
        r_data_n = mem[r_addr_i];
        if (!r_in_range) begin
            r_data_n = '0;
        end else if ((write_through_p != 0) && w_accept && (w_addr_i == r_addr_i)) begin
            r_data_n = w_merge;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_data_o <= '0;
            r_v_o    <= 1'b0;
        end else begin
            r_v_o <= r_accept;
            if (r_accept) begin
                r_data_o <= r_data_n;
            end
        end
    end

    // Storage has no reset; reset_n_i only blocks updates while reset is held.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            if (state_r == S_CLEAR) begin
                mem[cnt_r] <= init_val_p;
            end else if (w_accept) begin
                mem[w_addr_i] <= w_merge;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if ((sim_oob_check_p != 0) && reset_n_i && ready_o) begin
            if (w_v_i && !w_in_range) begin
                $error("bsg_mem_1r1w_sync_clear: write address %0d out of range (els_p=%0d)",
                       w_addr_i, els_p);
            end
            if (r_v_i && !r_in_range) begin
                $error("bsg_mem_1r1w_sync_clear: read address %0d out of range (els_p=%0d)",
                       r_addr_i, els_p);
            end
        end
    end

endmodule

// File: tb/tb_bsg_mem_1r1w_sync_clear.sv
module tb_bsg_mem_1r1w_sync_clear;

    logic        clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        reset_n;
    logic        clear;
    logic        w_v, r_v;
    logic [2:0]  w_addr, r_addr;
    logic [15:0] w_data, w_mask;
    logic        ready_a, ready_b, rv_a, rv_b;
    logic [15:0] rd_a, rd_b;

    logic        c_clear;
    logic        c_w_v, c_r_v;
    logic [2:0]  c_w_addr, c_r_addr;
    logic [15:0] c_w_data, c_w_mask;
    logic        c_ready, c_rv;
    logic [15:0] c_rd;

    int tests = 0;
    int fails = 0;

    bsg_mem_1r1w_sync_clear #(
        .width_p(16), .els_p(8), .write_through_p(1), .clear_on_reset_p(1),
        .init_val_p(16'hA5A5)
    ) u_a (
        .clk_i(clk_i), .reset_n_i(reset_n), .clear_i(clear), .ready_o(ready_a),
        .w_v_i(w_v), .w_addr_i(w_addr), .w_data_i(w_data), .w_mask_i(w_mask),
        .r_v_i(r_v), .r_addr_i(r_addr), .r_data_o(rd_a), .r_v_o(rv_a)
    );

    bsg_mem_1r1w_sync_clear #(
        .width_p(16), .els_p(8), .write_through_p(0), .clear_on_reset_p(1),
        .init_val_p(16'hA5A5)
    ) u_b (
        .clk_i(clk_i), .reset_n_i(reset_n), .clear_i(clear), .ready_o(ready_b),
        .w_v_i(w_v), .w_addr_i(w_addr), .w_data_i(w_data), .w_mask_i(w_mask),
        .r_v_i(r_v), .r_addr_i(r_addr), .r_data_o(rd_b), .r_v_o(rv_b)
    );

    bsg_mem_1r1w_sync_clear #(
        .width_p(16), .els_p(5), .write_through_p(0), .clear_on_reset_p(0),
        .init_val_p(16'h0000), .sim_oob_check_p(0)
    ) u_c (
        .clk_i(clk_i), .reset_n_i(reset_n), .clear_i(c_clear), .ready_o(c_ready),
        .w_v_i(c_w_v), .w_addr_i(c_w_addr), .w_data_i(c_w_data), .w_mask_i(c_w_mask),
        .r_v_i(c_r_v), .r_addr_i(c_r_addr), .r_data_o(c_rd), .r_v_o(c_rv)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; clear = 1'b0;
        w_v = 1'b0; w_addr = '0; w_data = '0; w_mask = '0;
        r_v = 1'b0; r_addr = '0;
        c_clear = 1'b0;
        c_w_v = 1'b0; c_w_addr = '0; c_w_data = '0; c_w_mask = '0;
        c_r_v = 1'b0; c_r_addr = '0;
        tick();
        tick();

        chk("rst_ready_a", 16'(ready_a), 16'd0);
        chk("rst_rv_a",    16'(rv_a),    16'd0);
        chk("rst_rdata_a", rd_a,         16'h0000);
        chk("rst_ready_c", 16'(c_ready), 16'd1);
        chk("rst_rdata_c", c_rd,         16'h0000);

        // Power-on sweep: 8 cycles busy, then ready.
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("sweep1_busy", 16'(ready_a), 16'd0);
            tick();
        end
        chk("sweep1_done_a", 16'(ready_a), 16'd1);
        chk("sweep1_done_b", 16'(ready_b), 16'd1);

        for (int i = 0; i < 8; i++) begin
            r_v = 1'b1; r_addr = 3'(i);
            tick();
            chk("init_rv",   16'(rv_a), 16'd1);
            chk("init_rd_a", rd_a,      16'hA5A5);
            chk("init_rd_b", rd_b,      16'hA5A5);
        end
        r_v = 1'b0;
        tick();
        chk("idle_rv",   16'(rv_a), 16'd0);
        chk("idle_hold", rd_a,      16'hA5A5);

        // Masked write merge.
        w_v = 1'b1; w_addr = 3'd3; w_data = 16'h1234; w_mask = 16'hFFFF;
        tick();
        w_data = 16'hFFCD; w_mask = 16'h00FF;
        tick();
        w_v = 1'b0; r_v = 1'b1; r_addr = 3'd3;
        tick();
        r_v = 1'b0;
        chk("mask_rd_a", rd_a, 16'h12CD);
        chk("mask_rd_b", rd_b, 16'h12CD);

        // Same-address write/read, old data 0000.
        w_v = 1'b1; w_addr = 3'd5; w_data = 16'h0000; w_mask = 16'hFFFF;
        tick();
        w_data = 16'hBEEF; w_mask = 16'hFF00; r_v = 1'b1; r_addr = 3'd5;
        tick();
        w_v = 1'b0;
        chk("wt1_rd",  rd_a, 16'hBE00);
        chk("wt0_rd",  rd_b, 16'h0000);
        tick();
        r_v = 1'b0;
        chk("wt1_after", rd_a, 16'hBE00);
        chk("wt0_after", rd_b, 16'hBE00);

        // clear_i with concurrent write; clear_i held into the sweep is ignored.
        clear = 1'b1; w_v = 1'b1; w_addr = 3'd2; w_data = 16'h1111; w_mask = 16'hFFFF;
        tick();
        w_v = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("sweep2_busy", 16'(ready_a), 16'd0);
            clear = (i < 3);
            r_v = 1'b1; r_addr = 3'd0;
            w_v = 1'b1; w_addr = 3'd0; w_data = 16'hDEAD; w_mask = 16'hFFFF;
            tick();
            chk("sweep2_rv", 16'(rv_a), 16'd0);
        end
        clear = 1'b0; r_v = 1'b0; w_v = 1'b0;
        chk("sweep2_done", 16'(ready_a), 16'd1);
        r_v = 1'b1; r_addr = 3'd2;
        tick();
        chk("clr_addr2", rd_a, 16'hA5A5);
        r_addr = 3'd0;
        tick();
        chk("clr_addr0", rd_a, 16'hA5A5);
        r_addr = 3'd3;
        tick();
        chk("clr_addr3", rd_b, 16'hA5A5);
        r_v = 1'b0;

        // Reset in the middle of a sweep restarts it from entry 0.
        for (int i = 0; i < 8; i++) begin
            w_v = 1'b1; w_addr = 3'(i); w_data = 16'(16'h1111 * (i + 1)); w_mask = 16'hFFFF;
            tick();
        end
        w_v = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_ready", 16'(ready_a), 16'd0);
        chk("midrst_rdata", rd_a,         16'h0000);
        chk("midrst_ready_c", 16'(c_ready), 16'd1);
        tick();
        reset_n = 1'b1;
        #1;
        chk("rel_ready_c", 16'(c_ready), 16'd1);
        for (int i = 0; i < 8; i++) begin
            chk("sweep3_busy", 16'(ready_a), 16'd0);
            tick();
        end
        chk("sweep3_done", 16'(ready_a), 16'd1);
        for (int i = 0; i < 8; i++) begin
            r_v = 1'b1; r_addr = 3'(i);
            tick();
            chk("sweep3_rd", rd_a, 16'hA5A5);
        end
        r_v = 1'b0;

        // els_p=5: out-of-range accesses.
        c_w_v = 1'b1; c_w_addr = 3'd1; c_w_data = 16'h5555; c_w_mask = 16'hFFFF;
        tick();
        c_w_addr = 3'd6; c_w_data = 16'h7777;
        tick();
        c_w_addr = 3'd5; c_w_data = 16'h9999;
        tick();
        c_w_v = 1'b0;
        c_r_v = 1'b1; c_r_addr = 3'd1;
        tick();
        chk("c_rd1", c_rd, 16'h5555);
        c_r_addr = 3'd6;
        tick();
        chk("c_oob6_rv", 16'(c_rv), 16'd1);
        chk("c_oob6_rd", c_rd,      16'h0000);
        c_r_addr = 3'd1;
        tick();
        chk("c_rd1_again", c_rd, 16'h5555);
        c_r_addr = 3'd5;
        tick();
        chk("c_oob5_rd", c_rd, 16'h0000);
        c_r_v = 1'b0;
        tick();
        chk("c_idle_rv", 16'(c_rv), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
